// File: rtl/adc_spi_responder.sv
// Converter-side model of the ADC's 4-wire SPI link: synchronizes the controller's pins,
// decodes the next-channel address from din and shifts 12-bit samples out on dout.
module adc_spi_responder #(
  parameter int          SYNC_STAGES  = 2,
  parameter logic [11:0] RESET_SAMPLE = 12'h000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        adc_sclk,
  input  logic        adc_cs_n,
  input  logic        adc_din,
  output logic        adc_dout,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [11:0] wr_data,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [2:0]  active_channel,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2,
    DONE      = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_s, cs_s, din_s;
  logic                   sclk_p, cs_p, din_p, din_a;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES+1:0] primed;

  // Edge pulses are registered, so din is delayed to line up with them.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sclk_s    <= '1;
      cs_s      <= '1;
      din_s     <= '0;
      sclk_p    <= 1'b1;
      cs_p      <= 1'b1;
      din_p     <= 1'b0;
      din_a     <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_rise   <= 1'b0;
      cs_fall   <= 1'b0;
      primed    <= '0;
    end else begin
      sclk_s    <= {sclk_s[SYNC_STAGES-2:0], adc_sclk};
      cs_s      <= {cs_s[SYNC_STAGES-2:0], adc_cs_n};
      din_s     <= {din_s[SYNC_STAGES-2:0], adc_din};
      sclk_p    <= sclk_s[SYNC_STAGES-1];
      cs_p      <= cs_s[SYNC_STAGES-1];
      din_p     <= din_s[SYNC_STAGES-1];
      din_a     <= din_p;
      sclk_rise <= sclk_s[SYNC_STAGES-1] & ~sclk_p;
      sclk_fall <= ~sclk_s[SYNC_STAGES-1] & sclk_p;
      cs_rise   <= cs_s[SYNC_STAGES-1] & ~cs_p;
      cs_fall   <= ~cs_s[SYNC_STAGES-1] & cs_p;
      primed    <= {primed[SYNC_STAGES:0], 1'b1};
    end
  end

  // Write port: a single-cycle strobe, no backpressure; wr_en is sampled every clock.
  logic [11:0] sample [8];

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < 8; i++) sample[i] <= RESET_SAMPLE;
    end else if (wr_en) begin
      sample[wr_addr] <= wr_data;
    end
  end

  state_t      state, state_nxt;
  logic        dout_nxt, done_nxt, abort_nxt;
  logic [3:0]  rcnt, rcnt_nxt, tx_idx;
  logic [15:0] tx_shift, tx_nxt, rx_shift, rx_nxt, rx_new;
  logic [2:0]  next_ch, next_ch_nxt, act_nxt;

  assign fsm_state = state;
  assign rx_new    = {rx_shift[14:0], din_a};
  assign tx_idx    = 4'd15 - rcnt;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state          <= WAIT_HIGH;
      adc_dout       <= 1'b0;
      frame_done     <= 1'b0;
      frame_abort    <= 1'b0;
      rcnt           <= '0;
      tx_shift       <= '0;
      rx_shift       <= '0;
      next_ch        <= '0;
      active_channel <= '0;
    end else begin
      state          <= state_nxt;
      adc_dout       <= dout_nxt;
      frame_done     <= done_nxt;
      frame_abort    <= abort_nxt;
      rcnt           <= rcnt_nxt;
      tx_shift       <= tx_nxt;
      rx_shift       <= rx_nxt;
      next_ch        <= next_ch_nxt;
      active_channel <= act_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dout_nxt    = adc_dout;
    done_nxt    = 1'b0;
    abort_nxt   = 1'b0;
    rcnt_nxt    = rcnt;
    tx_nxt      = tx_shift;
    rx_nxt      = rx_shift;
    next_ch_nxt = next_ch;
    act_nxt     = active_channel;
    case (state)
      WAIT_HIGH: begin
        dout_nxt = 1'b0;
        // Wait until the reset values have been flushed out of the cs_n chain.
        if (primed[SYNC_STAGES+1] && cs_p) state_nxt = IDLE;
      end
      IDLE: begin
        dout_nxt = 1'b0;
        if (cs_fall) begin
          state_nxt = ACTIVE;
          act_nxt   = next_ch;
          tx_nxt    = {4'b0000, sample[next_ch]};
          rx_nxt    = '0;
          rcnt_nxt  = '0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
          dout_nxt  = 1'b0;
        end else if (sclk_rise) begin
          rx_nxt   = rx_new;
          rcnt_nxt = rcnt + 4'd1;
          if (rcnt == 4'd15) begin
            next_ch_nxt = rx_new[13:11];
            done_nxt    = 1'b1;
            state_nxt   = DONE;
          end
        end else if (sclk_fall && rcnt != 4'd0) begin
          dout_nxt = tx_shift[tx_idx];
        end
      end
      DONE: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          dout_nxt  = 1'b0;
        end else if (sclk_fall) begin
          dout_nxt = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: a bit-banged SPI controller drives frames, and a
// monitor pops expected frame events and captured words from queues as they appear.
module tb_adc_spi_responder;

  localparam int PH = 8;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic        adc_sclk, adc_cs_n, adc_din, adc_dout;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;
  logic        frame_done, frame_abort;
  logic [2:0]  active_channel;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;

  logic [4:0]  exp_evt_q[$];   // {abort, done, channel}
  logic [31:0] exp_q[$];       // expected captured serial words
  logic [31:0] cap_q[$];       // words captured by the controller driver

  adc_spi_responder #(.SYNC_STAGES(2), .RESET_SAMPLE(12'h000)) dut (
    .clk_clk(clk),
    .reset_reset(reset_reset),
    .adc_sclk(adc_sclk),
    .adc_cs_n(adc_cs_n),
    .adc_din(adc_din),
    .adc_dout(adc_dout),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_done(frame_done),
    .frame_abort(frame_abort),
    .active_channel(active_channel),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic write_sample(input logic [2:0] a, input logic [11:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic run_frame(input int nrise, input logic [2:0] addr, input bit keep_word,
                           input bit collide, input logic [2:0] c_addr, input logic [11:0] c_data);
    logic [31:0] word;
    word = '0;
    @(negedge clk);
    adc_cs_n = 1'b0;
    if (collide) begin
      // Load happens on the clock edge two cycles after the synchronized fall.
      repeat (3) @(negedge clk);
      wr_en = 1'b1; wr_addr = c_addr; wr_data = c_data;
      @(negedge clk);
      wr_en = 1'b0;
      repeat (PH - 4) @(negedge clk);
    end else begin
      repeat (PH) @(negedge clk);
    end
    for (int k = 1; k <= nrise; k++) begin
      adc_sclk = 1'b0;
      adc_din  = (k >= 3 && k <= 5) ? addr[5-k] : 1'b0;
      repeat (PH) @(negedge clk);
      word = {word[30:0], adc_dout};
      adc_sclk = 1'b1;
      repeat (PH) @(negedge clk);
    end
    adc_din  = 1'b0;
    adc_cs_n = 1'b1;
    repeat (2 * PH) @(negedge clk);
    if (keep_word) cap_q.push_back(word);
  endtask

  task automatic expect_frame(input logic [2:0] ch, input logic [31:0] word);
    exp_evt_q.push_back({2'b01, ch});
    exp_q.push_back(word);
  endtask

  // scoreboard monitor
  initial begin
    logic [4:0]  got, want;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (frame_done || frame_abort) begin
        got = {frame_abort, frame_done, active_channel};
        if (exp_evt_q.size() == 0) begin
          check("unexpected_event", {27'd0, got}, 32'd0);
        end else begin
          want = exp_evt_q.pop_front();
          check("frame_event", {27'd0, got}, {27'd0, want});
        end
      end
      if (cap_q.size() > 0) begin
        w = cap_q.pop_front();
        if (exp_q.size() == 0) check("unexpected_word", w, 32'hdead_beef);
        else check("frame_word", w, exp_q.pop_front());
      end
    end
  end

  // stimulus
  initial begin
    reset_reset = 1'b1;
    adc_sclk = 1'b1; adc_cs_n = 1'b1; adc_din = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (4) @(negedge clk);
    check("reset_dout", {31'd0, adc_dout}, 32'd0);
    check("reset_done", {31'd0, frame_done}, 32'd0);
    check("reset_abort", {31'd0, frame_abort}, 32'd0);
    check("reset_channel", {29'd0, active_channel}, 32'd0);
    reset_reset = 1'b0;
    repeat (10) @(negedge clk);

    write_sample(3'd0, 12'hA5C);
    write_sample(3'd5, 12'hFFF);
    write_sample(3'd6, 12'h666);
    write_sample(3'd2, 12'h222);
    write_sample(3'd3, 12'h333);

    // basic frame, then channel select chain
    expect_frame(3'd0, 32'h0A5C); run_frame(16, 3'd0, 1'b1, 1'b0, 3'd0, 12'h0);
    expect_frame(3'd0, 32'h0A5C); run_frame(16, 3'd5, 1'b1, 1'b0, 3'd0, 12'h0);
    expect_frame(3'd5, 32'h0FFF); run_frame(16, 3'd0, 1'b1, 1'b0, 3'd0, 12'h0);
    expect_frame(3'd0, 32'h0A5C); run_frame(16, 3'd6, 1'b1, 1'b0, 3'd0, 12'h0);

    // abort after 9 rises carrying address 3; next_ch stays 6
    exp_evt_q.push_back({2'b10, 3'd6});
    run_frame(9, 3'd3, 1'b0, 1'b0, 3'd0, 12'h0);
    expect_frame(3'd6, 32'h0666); run_frame(16, 3'd2, 1'b1, 1'b0, 3'd0, 12'h0);

    // write collision on the loaded channel
    expect_frame(3'd2, 32'h0222); run_frame(16, 3'd2, 1'b1, 1'b1, 3'd2, 12'h2B2);
    expect_frame(3'd2, 32'h02B2); run_frame(16, 3'd5, 1'b1, 1'b0, 3'd0, 12'h0);
    check("channel_before_reset", {29'd0, active_channel}, 32'd2);

    // reset after 7 rises of a channel-5 frame, released with cs_n still low
    @(negedge clk);
    adc_cs_n = 1'b0;
    repeat (PH) @(negedge clk);
    for (int k = 1; k <= 7; k++) begin
      adc_sclk = 1'b0; adc_din = (k == 3 || k == 4) ? 1'b1 : 1'b0;
      repeat (PH) @(negedge clk);
      adc_sclk = 1'b1;
      repeat (PH) @(negedge clk);
    end
    adc_din = 1'b0;
    reset_reset = 1'b1;
    repeat (3) @(negedge clk);
    reset_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      adc_sclk = 1'b0;
      repeat (PH) @(negedge clk);
      check("post_reset_dout_low", {31'd0, adc_dout}, 32'd0);
      adc_sclk = 1'b1;
      repeat (PH) @(negedge clk);
      check("post_reset_dout_high", {31'd0, adc_dout}, 32'd0);
    end
    check("post_reset_channel", {29'd0, active_channel}, 32'd0);
    adc_cs_n = 1'b1;
    repeat (2 * PH) @(negedge clk);
    expect_frame(3'd0, 32'h0000); run_frame(16, 3'd0, 1'b1, 1'b0, 3'd0, 12'h0);

    // 20 sclk cycles in one frame: trailing bits are zero, one frame_done
    write_sample(3'd0, 12'hC3A);
    expect_frame(3'd0, 32'h0C3A0); run_frame(20, 3'd0, 1'b1, 1'b0, 3'd0, 12'h0);

    repeat (20) @(negedge clk);
    check("events_left", exp_evt_q.size(), 32'd0);
    check("words_left", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
